// File: rtl/unidade_controle_pkg.sv
// Shared types for the Polilock control unit: state codes and the
// bundle of Moore control outputs.
package unidade_controle_pkg;

  // 4-bit state codes, also shown on db_estado and used by the display decoder
  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARACAO    = 4'd1,
    ESPERA        = 4'd2,
    ZERA_END      = 4'd3,
    CARREGA       = 4'd4,
    COMPARA       = 4'd5,
    PROXIMO       = 4'd6,
    ERRO_SENHA    = 4'd7,
    CHECA_TENT    = 4'd8,
    BLOQUEADO_S   = 4'd9,
    ABERTO_S      = 4'd10,
    GRAVA_ZERA    = 4'd11,
    GRAVA_CARREGA = 4'd12,
    GRAVA         = 4'd13,
    GRAVA_PROXIMO = 4'd14
  } estado_t;

  typedef struct packed {
    logic zeraC;
    logic contaC;
    logic zeraT;
    logic contaT;
    logic escreve;
    logic pronto;
    logic aberto;
    logic bloqueado;
    logic erro;
  } saidas_t;

  // Moore output decode: each state maps to a fixed set of control lines
  function automatic saidas_t decodificaSaidas(input estado_t estado);
    saidas_t s;
    s = '0;
    case (estado)
      PREPARACAO:    begin s.zeraC = 1'b1; s.zeraT = 1'b1; end
      ESPERA:        s.pronto = 1'b1;
      ZERA_END:      s.zeraC = 1'b1;
      PROXIMO:       s.contaC = 1'b1;
      ERRO_SENHA:    begin s.erro = 1'b1; s.contaT = 1'b1; end
      BLOQUEADO_S:   s.bloqueado = 1'b1;
      ABERTO_S:      begin s.aberto = 1'b1; s.zeraT = 1'b1; end
      GRAVA_ZERA:    begin s.aberto = 1'b1; s.zeraC = 1'b1; end
      GRAVA_CARREGA: s.aberto = 1'b1;
      GRAVA:         begin s.aberto = 1'b1; s.escreve = 1'b1; end
      GRAVA_PROXIMO: begin s.aberto = 1'b1; s.contaC = 1'b1; end
      default:       s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_temporizador.sv
// Lockout timer: counts while enabled, holds at the terminal value
// instead of wrapping, and is cleared whenever the lock is not blocked.
module temporizador_bloqueio #(
  parameter int BLOQ_CICLOS = 50000000,
  parameter int W_BLOQ      = 26
) (
  input  logic clock,
  input  logic reset,
  input  logic i_limpa,
  input  logic i_conta,
  output logic o_fim
);

  logic [W_BLOQ-1:0] r_contagem;
  logic              w_fim;

  assign w_fim = (r_contagem == W_BLOQ'(BLOQ_CICLOS - 1));
  assign o_fim = w_fim;

  // Clear has priority; counting stops at the terminal value so it never wraps
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contagem <= '0;
    end else if (i_limpa) begin
      r_contagem <= '0;
    end else if (i_conta && !w_fim) begin
      r_contagem <= r_contagem + 1'b1;
    end
  end

endmodule

// File: rtl/unidade_controle.sv
// Polilock control unit: Moore FSM that verifies a 10-character password,
// counts failed attempts, enforces a timed lockout and records a new
// password while the lock is open. Outputs drive the datapath 1:1.
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter int BLOQ_CICLOS = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       senha_pronta,
  input  logic       cadastrar,
  input  logic       fechar,
  input  logic       igual,
  input  logic       fim_verificacao,
  input  logic       excedeu,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraT,
  output logic       contaT,
  output logic       escreve,
  output logic       pronto,
  output logic       aberto,
  output logic       bloqueado,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam int W_BLOQ = (BLOQ_CICLOS > 2) ? $clog2(BLOQ_CICLOS) : 1;

  estado_t r_estado;
  estado_t w_proximo;
  saidas_t r_saidas;
  logic    w_timerFim;
  logic    w_timerLimpa;
  logic    w_timerConta;

  // The timer only runs in lockout; every other state keeps it at zero
  assign w_timerConta = (r_estado == BLOQUEADO_S);
  assign w_timerLimpa = (r_estado != BLOQUEADO_S);

  temporizador_bloqueio #(
    .BLOQ_CICLOS (BLOQ_CICLOS),
    .W_BLOQ      (W_BLOQ)
  ) u_temporizador (
    .clock   (clock),
    .reset   (reset),
    .i_limpa (w_timerLimpa),
    .i_conta (w_timerConta),
    .o_fim   (w_timerFim)
  );

  // Next-state logic; user requests are only looked at in the states that honour them
  always_comb begin
    w_proximo = INICIAL;
    case (r_estado)
      INICIAL:       w_proximo = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:    w_proximo = ESPERA;
      ESPERA:        w_proximo = senha_pronta ? ZERA_END : ESPERA;
      ZERA_END:      w_proximo = CARREGA;
      CARREGA:       w_proximo = COMPARA;
      COMPARA:       w_proximo = !igual ? ERRO_SENHA :
                                 (fim_verificacao ? ABERTO_S : PROXIMO);
      PROXIMO:       w_proximo = CARREGA;
      ERRO_SENHA:    w_proximo = CHECA_TENT;
      CHECA_TENT:    w_proximo = excedeu ? BLOQUEADO_S : ESPERA;
      BLOQUEADO_S:   w_proximo = w_timerFim ? PREPARACAO : BLOQUEADO_S;
      ABERTO_S:      w_proximo = fechar ? PREPARACAO :
                                 ((cadastrar && senha_pronta) ? GRAVA_ZERA : ABERTO_S);
      GRAVA_ZERA:    w_proximo = GRAVA_CARREGA;
      GRAVA_CARREGA: w_proximo = GRAVA;
      GRAVA:         w_proximo = fim_verificacao ? ABERTO_S : GRAVA_PROXIMO;
      GRAVA_PROXIMO: w_proximo = GRAVA_CARREGA;
      default:       w_proximo = INICIAL;
    endcase
  end

  // State register; outputs are registered from the decode of the next state so they always match r_estado
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= INICIAL;
      r_saidas <= '0;
    end else begin
      r_estado <= w_proximo;
      r_saidas <= decodificaSaidas(w_proximo);
    end
  end

  assign zeraC     = r_saidas.zeraC;
  assign contaC    = r_saidas.contaC;
  assign zeraT     = r_saidas.zeraT;
  assign contaT    = r_saidas.contaT;
  assign escreve   = r_saidas.escreve;
  assign pronto    = r_saidas.pronto;
  assign aberto    = r_saidas.aberto;
  assign bloqueado = r_saidas.bloqueado;
  assign erro      = r_saidas.erro;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: a small behavioural datapath (RAM, serial
// buffer, address and attempt counters) answers the FSM, and each scenario
// checks event counts derived from the password rules.
module tb_unidade_controle;

  localparam int BLOQ     = 8;
  localparam int MAX_TENT = 3;
  localparam int NCHAR    = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       senha_pronta = 1'b0;
  logic       cadastrar = 1'b0;
  logic       fechar = 1'b0;
  logic       igual;
  logic       fim_verificacao;
  logic       excedeu;
  logic       zeraC, contaC, zeraT, contaT, escreve;
  logic       pronto, aberto, bloqueado, erro;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram         [NCHAR];
  logic [7:0] ramInicial  [NCHAR];
  logic [7:0] senhaSerial [NCHAR];
  logic [7:0] senhaNova   [NCHAR];
  logic       iniciaRam = 1'b0;
  int         modeloEnd = 0;
  int         modeloTent = 0;

  int nContaC = 0, nContaT = 0, nErro = 0, nEscreve = 0;
  int nCompara = 0, nBloq = 0, nAbertoBaixo = 0;
  int escritos[$];

  unidade_controle #(.BLOQ_CICLOS(BLOQ)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .senha_pronta(senha_pronta),
    .cadastrar(cadastrar), .fechar(fechar), .igual(igual),
    .fim_verificacao(fim_verificacao), .excedeu(excedeu),
    .zeraC(zeraC), .contaC(contaC), .zeraT(zeraT), .contaT(contaT),
    .escreve(escreve), .pronto(pronto), .aberto(aberto),
    .bloqueado(bloqueado), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Behavioural datapath: counters and RAM react to the control lines at the clock edge
  always @(posedge clock) begin
    if (iniciaRam) begin
      for (int i = 0; i < NCHAR; i++) ram[i] <= ramInicial[i];
    end else if (escreve && modeloEnd < NCHAR) begin
      ram[modeloEnd] <= senhaSerial[modeloEnd];
    end
    if (zeraC) modeloEnd <= 0;
    else if (contaC) modeloEnd <= modeloEnd + 1;
    if (zeraT) modeloTent <= 0;
    else if (contaT) modeloTent <= modeloTent + 1;
  end

  assign igual           = (modeloEnd < NCHAR) ? (ram[modeloEnd] == senhaSerial[modeloEnd]) : 1'b0;
  assign fim_verificacao = (modeloEnd == NCHAR - 1);
  assign excedeu         = (modeloTent == MAX_TENT);

  // Event monitor sampled on the falling edge, away from state changes
  always @(negedge clock) begin
    if (!reset) begin
      nContaC  += int'(contaC);
      nContaT  += int'(contaT);
      nErro    += int'(erro);
      nEscreve += int'(escreve);
      nBloq    += int'(bloqueado);
      if (db_estado == 4'd5) nCompara++;
      if (escreve) escritos.push_back(modeloEnd);
      if (db_estado >= 4'd11 && db_estado <= 4'd14 && !aberto) nAbertoBaixo++;
    end
  end

  task automatic waitState(input logic [3:0] code, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clock); #1;
      if (db_estado == code) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < NCHAR; i++) ramInicial[i] = 8'($urandom);
    iniciaRam = 1'b1;
    @(posedge clock); #1;
    iniciaRam = 1'b0;
    checks++;
    if ({db_estado, zeraC, contaC, zeraT, contaT, escreve, pronto, aberto, bloqueado, erro} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got estado=%0d outs=%b required estado=0 outs=0", db_estado,
               {zeraC, contaC, zeraT, contaT, escreve, pronto, aberto, bloqueado, erro});
    end
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (db_estado !== 4'd0) begin
      errors++;
      $display("[TB] FAIL idle_without_iniciar: got %0d required 0", db_estado);
    end
  endtask

  task automatic iniciarSessao;
    bit ok;
    iniciar = 1'b1;
    waitState(4'd1, 3, ok);
    iniciar = 1'b0;
    if (ok) waitState(4'd2, 3, ok);
    checks++;
    if (!ok || pronto !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_to_espera: got estado=%0d pronto=%b required estado=2 pronto=1", db_estado, pronto);
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    iniciarSessao();
    for (int i = 0; i < NCHAR; i++) senhaSerial[i] = ram[i];
    senha_pronta = 1'b1;
    waitState(4'd5, 10, ok);
    senha_pronta = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL reach_compara: got estado=%0d required 5", db_estado);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({db_estado, zeraC, contaC, zeraT, contaT, escreve, pronto, aberto, bloqueado, erro} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got estado=%0d outs=%b required estado=0 outs=0", db_estado,
               {zeraC, contaC, zeraT, contaT, escreve, pronto, aberto, bloqueado, erro});
    end
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (db_estado !== 4'd0) begin
      errors++;
      $display("[TB] FAIL stay_inicial_after_reset: got %0d required 0", db_estado);
    end
  endtask

  task automatic test_open;
    bit ok;
    int b0, b1;
    b0 = nContaC; b1 = nCompara;
    for (int i = 0; i < NCHAR; i++) senhaSerial[i] = ram[i];
    senha_pronta = 1'b1;
    waitState(4'd3, 3, ok);
    senha_pronta = 1'b0;
    if (ok) waitState(4'd10, 200, ok);
    checks++;
    if (!ok || aberto !== 1'b1 || zeraT !== 1'b1) begin
      errors++;
      $display("[TB] FAIL open: got estado=%0d aberto=%b zeraT=%b required 10 1 1", db_estado, aberto, zeraT);
    end
    checks++;
    if (nContaC - b0 != NCHAR - 1) begin
      errors++;
      $display("[TB] FAIL open_contaC: got %0d required %0d", nContaC - b0, NCHAR - 1);
    end
    checks++;
    if (nCompara - b1 != NCHAR) begin
      errors++;
      $display("[TB] FAIL open_compares: got %0d required %0d", nCompara - b1, NCHAR);
    end
  endtask

  task automatic test_cadastro;
    bit ok;
    bit ordemOk;
    bit ramOk;
    int b0, b1, q0, b2;
    b0 = nEscreve; b1 = nAbertoBaixo; q0 = escritos.size();
    for (int i = 0; i < NCHAR; i++) senhaNova[i] = 8'($urandom);
    senhaNova[0] = ram[0] ^ 8'h5A;
    for (int i = 0; i < NCHAR; i++) senhaSerial[i] = senhaNova[i];
    cadastrar = 1'b1;
    senha_pronta = 1'b1;
    waitState(4'd11, 3, ok);
    cadastrar = 1'b0;
    senha_pronta = 1'b0;
    b2 = nContaC;
    if (ok) waitState(4'd10, 200, ok);
    checks++;
    if (!ok || aberto !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cadastro_return: got estado=%0d aberto=%b required 10 1", db_estado, aberto);
    end
    checks++;
    if (nEscreve - b0 != NCHAR) begin
      errors++;
      $display("[TB] FAIL cadastro_escreve_count: got %0d required %0d", nEscreve - b0, NCHAR);
    end
    ordemOk = (escritos.size() - q0 == NCHAR);
    for (int i = 0; i < NCHAR && ordemOk; i++) if (escritos[q0 + i] != i) ordemOk = 1'b0;
    checks++;
    if (!ordemOk) begin
      errors++;
      $display("[TB] FAIL cadastro_addr_order: got %0d writes, order ok=%0d required 10 writes at 0..9",
               escritos.size() - q0, ordemOk);
    end
    ramOk = 1'b1;
    for (int i = 0; i < NCHAR; i++) if (ram[i] !== senhaNova[i]) ramOk = 1'b0;
    checks++;
    if (!ramOk) begin
      errors++;
      $display("[TB] FAIL cadastro_ram: got ram[0]=%h required %h", ram[0], senhaNova[0]);
    end
    checks++;
    if (nAbertoBaixo - b1 != 0 || nContaC - b2 != NCHAR - 1) begin
      errors++;
      $display("[TB] FAIL cadastro_aberto_contaC: got aberto_low=%0d contaC=%0d required 0 %0d",
               nAbertoBaixo - b1, nContaC - b2, NCHAR - 1);
    end
  endtask

  task automatic test_fechar_prioridade;
    bit ok;
    int b0;
    b0 = nEscreve;
    fechar = 1'b1;
    cadastrar = 1'b1;
    senha_pronta = 1'b1;
    @(posedge clock); #1;
    fechar = 1'b0;
    cadastrar = 1'b0;
    senha_pronta = 1'b0;
    checks++;
    if (db_estado !== 4'd1 || zeraT !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fechar_priority: got estado=%0d zeraT=%b required 1 1", db_estado, zeraT);
    end
    waitState(4'd2, 3, ok);
    checks++;
    if (!ok || pronto !== 1'b1 || nEscreve - b0 != 0) begin
      errors++;
      $display("[TB] FAIL fechar_to_espera: got estado=%0d escreve_count=%0d required 2 0", db_estado, nEscreve - b0);
    end
  endtask

  task automatic test_mismatch(input int k, input int tentEsperadas);
    bit ok;
    int b0, b1, b2, b3;
    b0 = nCompara; b1 = nContaC; b2 = nErro; b3 = nContaT;
    for (int i = 0; i < NCHAR; i++) senhaSerial[i] = ram[i];
    senhaSerial[k] = ram[k] ^ 8'(1 + $urandom_range(0, 254));
    senha_pronta = 1'b1;
    waitState(4'd3, 3, ok);
    senha_pronta = 1'b0;
    if (ok) waitState(4'd2, 100, ok);
    checks++;
    if (!ok || pronto !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mismatch_return k=%0d: got estado=%0d required 2", k, db_estado);
    end
    checks++;
    if (nCompara - b0 != k + 1 || nContaC - b1 != k) begin
      errors++;
      $display("[TB] FAIL mismatch_compares k=%0d: got %0d/%0d required %0d/%0d", k,
               nCompara - b0, nContaC - b1, k + 1, k);
    end
    checks++;
    if (nErro - b2 != 1 || nContaT - b3 != 1 || modeloTent != tentEsperadas) begin
      errors++;
      $display("[TB] FAIL mismatch_erro k=%0d: got erro=%0d contaT=%0d tent=%0d required 1 1 %0d", k,
               nErro - b2, nContaT - b3, modeloTent, tentEsperadas);
    end
  endtask

  task automatic test_lockout;
    bit ok;
    int k, b0, b1, b2, b3, ciclos;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    iniciarSessao();
    k = $urandom_range(0, NCHAR - 1);
    for (int i = 0; i < NCHAR; i++) senhaSerial[i] = ram[i];
    senhaSerial[k] = ~ram[k];
    b0 = nErro; b1 = nContaT; b2 = nCompara; b3 = nBloq;
    senha_pronta = 1'b1;
    waitState(4'd9, 500, ok);
    senha_pronta = 1'b0;
    checks++;
    if (!ok || bloqueado !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lockout_enter: got estado=%0d bloqueado=%b required 9 1", db_estado, bloqueado);
    end
    checks++;
    if (nErro - b0 != MAX_TENT || nContaT - b1 != MAX_TENT || nCompara - b2 != MAX_TENT * (k + 1)) begin
      errors++;
      $display("[TB] FAIL lockout_attempts k=%0d: got erro=%0d contaT=%0d cmp=%0d required %0d %0d %0d", k,
               nErro - b0, nContaT - b1, nCompara - b2, MAX_TENT, MAX_TENT, MAX_TENT * (k + 1));
    end
    ciclos = ok ? 1 : 0;
    for (int c = 0; c < 50 && ok; c++) begin
      @(posedge clock); #1;
      if (db_estado == 4'd9) ciclos++;
      else break;
    end
    checks++;
    if (ciclos != BLOQ || nBloq - b3 != BLOQ) begin
      errors++;
      $display("[TB] FAIL lockout_length: got state=%0d bloqueado=%0d required %0d", ciclos, nBloq - b3, BLOQ);
    end
    checks++;
    if (db_estado !== 4'd1 || zeraT !== 1'b1 || bloqueado !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lockout_exit: got estado=%0d zeraT=%b required 1 1", db_estado, zeraT);
    end
    @(posedge clock); #1;
    checks++;
    if (db_estado !== 4'd2 || pronto !== 1'b1 || modeloTent != 0) begin
      errors++;
      $display("[TB] FAIL lockout_espera: got estado=%0d tent=%0d required 2 0", db_estado, modeloTent);
    end
  endtask

  task automatic fecharTrava;
    bit ok;
    fechar = 1'b1;
    @(posedge clock); #1;
    fechar = 1'b0;
    waitState(4'd2, 3, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL close_lock: got estado=%0d required 2", db_estado);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    iniciarSessao();
    test_open();
    test_cadastro();
    test_fechar_prioridade();
    test_open();
    fecharTrava();
    test_mismatch(3, 1);
    test_mismatch($urandom_range(0, NCHAR - 1), 2);
    test_lockout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
